// File: rtl/cache_pkg.sv
// Shared types and constants for the L1 data-cache miss handler.
// Holds the miss FSM state encoding and the default datapath widths.
package cache_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;
    localparam int unsigned ADDR_WIDTH_DEFAULT = 32;

    // Byte-offset bits within a data word; cleared to form word-aligned addresses.
    localparam int unsigned WORD_OFFSET = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWb   = 2'd1,
        StFill = 2'd2,
        StResp = 2'd3
    } miss_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// Synchronous active-high reset clears the count.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// L1 data-cache miss handler: optional dirty-victim writeback, then a word fill
// returned to the cache as a one-cycle pulse, with saturating miss/writeback counters.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  victim_dirty,
    input  logic [ADDR_WIDTH-1:0] victim_addr,
    input  logic [DATA_WIDTH-1:0] victim_data,
    output logic                  stall,
    output logic                  fill_valid,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  miss_count,
    output logic [CNT_WIDTH-1:0]  wb_count
);

    miss_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
    logic                  miss_inc;
    logic                  wb_inc;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] aligned;
        aligned = addr;
        aligned[WORD_OFFSET-1:0] = '0;
        return aligned;
    endfunction

    // mem_addr/mem_wdata are registers loaded on entry to WB/FILL, so they double as
    // the captured victim address/data and hold their value once the access ends.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_data_d = fill_data_q;
        miss_inc    = 1'b0;
        wb_inc      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        fill_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    miss_inc    = 1'b1;
                    miss_addr_d = word_align(miss_addr);
                    if (victim_dirty) begin
                        state_d     = StWb;
                        mem_addr_d  = word_align(victim_addr);
                        mem_wdata_d = victim_data;
                    end else begin
                        state_d    = StFill;
                        mem_addr_d = word_align(miss_addr);
                    end
                end
            end
            StWb: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    wb_inc     = 1'b1;
                    state_d    = StFill;
                    mem_addr_d = miss_addr_q;
                end
            end
            StFill: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    fill_data_d = mem_rdata;
                    state_d     = StResp;
                end
            end
            StResp: begin
                fill_valid = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            miss_addr_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fill_data_q <= fill_data_d;
        end
    end

    // Combinational so the pipeline freezes in the very cycle the miss is raised.
    assign stall     = miss | (state_q != StIdle);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign fill_data = fill_data_q;

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_miss_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (miss_inc),
        .count(miss_count)
    );

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_wb_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (wb_inc),
        .count(wb_count)
    );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: directed misses push expected memory
// transfers, fills and stall lengths; a monitor pops and compares them.
module tb_cache_miss_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    // Narrow counters keep the saturation run short (257 misses instead of 65 537).
    localparam int unsigned CNT_W = 8;
    localparam int          SAT_N = 257;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_txn_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             miss;
    logic [AW-1:0]    miss_addr;
    logic             victim_dirty;
    logic [AW-1:0]    victim_addr;
    logic [DW-1:0]    victim_data;
    logic             stall;
    logic             fill_valid;
    logic [DW-1:0]    fill_data;
    logic             mem_req;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_ready;
    logic [DW-1:0]    mem_rdata;
    logic [CNT_W-1:0] miss_count;
    logic [CNT_W-1:0] wb_count;

    mem_txn_t exp_mem[$];
    logic [DW-1:0] exp_fill[$];
    int exp_stall[$];

    int tests  = 0;
    int failed = 0;
    int wait_cfg = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    cache_miss_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .miss        (miss),
        .miss_addr   (miss_addr),
        .victim_dirty(victim_dirty),
        .victim_addr (victim_addr),
        .victim_data (victim_data),
        .stall       (stall),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .miss_count  (miss_count),
        .wb_count    (wb_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: inserts wait_cfg low-ready cycles before each accepted request.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                wcnt = 0;
                mem_ready = 1'b1;
            end else if (wcnt < wait_cfg) begin
                wcnt++;
                mem_ready = 1'b0;
            end else begin
                wcnt = 0;
                mem_ready = 1'b1;
            end
        end
    end

    // Monitor: transfers, handshake stability, fills and stall run lengths.
    initial begin
        mem_txn_t t;
        bit hold_pend;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_wdata;
        logic h_we;
        int run;
        hold_pend = 1'b0;
        run = 0;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (hold_pend) begin
                    check("hold_req_we", {mem_req, mem_we}, {1'b1, h_we});
                    check("hold_addr", mem_addr, h_addr);
                    check("hold_wdata", mem_wdata, h_wdata);
                end
                hold_pend = mem_req && !mem_ready && !rst;
                h_we = mem_we;
                h_addr = mem_addr;
                h_wdata = mem_wdata;

                if (mem_req && mem_ready) begin
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected", {mem_we, mem_addr}, 0);
                    end else begin
                        t = exp_mem.pop_front();
                        check("mem_we", mem_we, t.we);
                        check("mem_addr", mem_addr, t.addr);
                        if (t.we) check("mem_wdata", mem_wdata, t.wdata);
                    end
                end

                if (fill_valid) begin
                    if (exp_fill.size() == 0) check("fill_unexpected", fill_data, 0);
                    else check("fill_data", fill_data, exp_fill.pop_front());
                end

                if (stall) begin
                    run++;
                end else if (run > 0) begin
                    if (exp_stall.size() == 0) check("stall_unexpected", run, 0);
                    else check("stall_cycles", run, exp_stall.pop_front());
                    run = 0;
                end
            end else begin
                hold_pend = 1'b0;
                run = 0;
            end
        end
    end

    task automatic do_miss(input logic [AW-1:0] maddr, input logic dirty,
                           input logic [AW-1:0] vaddr, input logic [DW-1:0] vdata,
                           input logic [DW-1:0] rdata, input int waits,
                           input int exp_lat, input bit disturb);
        int lat;
        bit seen;
        mem_txn_t t;
        @(negedge clk);
        wait_cfg = waits;
        miss = 1'b1;
        miss_addr = maddr;
        victim_dirty = dirty;
        victim_addr = vaddr;
        victim_data = vdata;
        mem_rdata = rdata;
        if (dirty) begin
            t = '{1'b1, vaddr & ~32'h3, vdata};
            exp_mem.push_back(t);
        end
        t = '{1'b0, maddr & ~32'h3, '0};
        exp_mem.push_back(t);
        exp_fill.push_back(rdata);
        exp_stall.push_back(exp_lat);
        lat = 0;
        seen = 1'b0;
        for (int c = 1; c <= 64 && !seen; c++) begin
            #1;
            if (fill_valid) begin
                seen = 1'b1;
                lat = c;
            end else begin
                if (disturb && c == 2) begin
                    miss_addr = 32'hFFFF_FFFC;
                    victim_addr = 32'hEEEE_EEE0;
                    victim_data = 32'hBAD0_BAD0;
                    victim_dirty = 1'b0;
                end
                @(negedge clk);
            end
        end
        miss = 1'b0;
        check("fill_latency", lat, exp_lat);
        @(negedge clk);
    endtask

    initial begin
        mem_txn_t t;
        int fills;
        rst = 1'b1;
        miss = 1'b0;
        miss_addr = '0;
        victim_dirty = 1'b0;
        victim_addr = '0;
        victim_data = '0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_fill_valid", fill_valid, 1'b0);
        check("rst_fill_data", fill_data, 0);
        check("rst_mem_req_we", {mem_req, mem_we}, 2'b00);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_counts", {miss_count, wb_count}, 0);
        miss = 1'b1;
        #1;
        check("rst_stall_follows_miss", stall, 1'b1);
        miss = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Clean miss, ready tied high.
        do_miss(32'h0000_1006, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 3, 1'b0);
        #1;
        check("clean_miss_count", miss_count, 1);
        check("clean_wb_count", wb_count, 0);

        // Dirty miss.
        do_miss(32'h0000_3008, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'hA1B2_C3D4, 0, 4, 1'b0);
        #1;
        check("dirty_miss_count", miss_count, 2);
        check("dirty_wb_count", wb_count, 1);

        // Five wait states in both WB and FILL: 1 + 6 + 6 + 1.
        do_miss(32'h0000_5001, 1'b1, 32'h0000_4003, 32'hCAFE_F00D, 32'h0BAD_CAFE, 5, 14, 1'b0);
        #1;
        check("wait_miss_count", miss_count, 3);
        check("wait_wb_count", wb_count, 2);

        // Inputs disturbed during WB must not reach memory.
        do_miss(32'h0000_7000, 1'b1, 32'h0000_6000, 32'h1111_2222, 32'h3333_4444, 2, 8, 1'b0 | 1'b1);
        #1;
        check("dist_miss_count", miss_count, 4);
        check("dist_wb_count", wb_count, 3);

        // Back-to-back clean misses drive miss_count into saturation.
        @(negedge clk);
        wait_cfg = 0;
        miss = 1'b1;
        victim_dirty = 1'b0;
        miss_addr = '0;
        mem_rdata = 32'h5A5A_0000;
        for (int i = 0; i < SAT_N; i++) begin
            t = '{1'b0, AW'(i) << 4, '0};
            exp_mem.push_back(t);
            exp_fill.push_back(32'h5A5A_0000);
        end
        exp_stall.push_back(3 * SAT_N);
        fills = 0;
        for (int c = 0; c < 3 * SAT_N + 20 && fills < SAT_N; c++) begin
            #1;
            if (fill_valid) begin
                fills++;
                miss_addr = AW'(fills) << 4;
                if (fills == SAT_N) miss = 1'b0;
            end
            @(negedge clk);
        end
        check("sat_fills", fills, SAT_N);
        #1;
        check("sat_miss_count", miss_count, {CNT_W{1'b1}});
        check("sat_wb_count", wb_count, 3);

        // Reset while FILL waits on memory.
        @(negedge clk);
        wait_cfg = 100;
        miss = 1'b1;
        miss_addr = 32'h0000_8000;
        victim_dirty = 1'b0;
        exp_stall.push_back(3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        miss = 1'b0;
        #1;
        check("pre_rst_fill_req", {mem_req, mem_we, mem_ready}, 3'b100);
        @(negedge clk);
        #1;
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_fill_valid", fill_valid, 1'b0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_counts", {miss_count, wb_count}, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_fill_data", fill_data, 0);
        rst = 1'b0;
        wait_cfg = 0;

        repeat (3) @(negedge clk);
        #2;
        check("mem_queue_empty", exp_mem.size(), 0);
        check("fill_queue_empty", exp_fill.size(), 0);
        check("stall_queue_empty", exp_stall.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog expired");
    end

endmodule
